atmega_clk_prescaler: RTL

Parametrised clock-enable generator for the ATmega core.
- System prescaler: CLKPR-style register with a timed change-enable sequence. Produces `sys_ce`, one pulse every 2^CLKPS clocks.
- NUM_CH independent fractional-N channels: 16-bit phase-increment DDS accumulators. Each produces a one-cycle clock enable plus a toggle square wave.
- Replaces derived clocks with enables in the single `clk` domain. Sits on the I/O data bus beside the timer peripherals.

---
 rtl/atmega_clk_prescaler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/atmega_clk_prescaler.sv
// Clock-enable generator: CLKPR-style system prescaler plus NUM_CH 16-bit DDS channels.
// Define ATMEGA_CLK_PRESCALER_CH_GATE_EN to advance channel accumulators only on sys_ce.
module atmega_clk_prescaler #(
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int CLKPR_ADDR        = 'h61,
  parameter int CLKFRQ_ADDR       = 'h62,
  parameter int NUM_CH            = 2,
  parameter int ACC_W             = 16,
  parameter int CLKPS_RST         = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  output logic                         sys_ce,
  output logic [NUM_CH-1:0]            ch_ce,
  output logic [NUM_CH-1:0]            ch_tog
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] PR_A = BUS_ADDR_DATA_LEN'(CLKPR_ADDR);
  localparam logic [3:0] PS_RST = 4'(CLKPS_RST);

  logic [3:0]       clkps;
  logic [3:0]       pending;
  logic [2:0]       win_cnt;
  logic [7:0]       cnt;
  logic [7:0]       temp;
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];

  logic             win_active;
  logic             pr_sel;
  logic [NUM_CH-1:0] sel_lo;
  logic [NUM_CH-1:0] sel_hi;
  logic             frq_lo;
  logic             frq_hi;
  logic [ACC_W-1:0] sel_inc;
  logic [3:0]       eff_ps;
  logic [7:0]       cnt_mask;
  logic             term;
  logic [3:0]       new_ps;
  logic             adv;
  logic [7:0]       rd_val;

  assign win_active = (win_cnt != 3'd0);
  assign pr_sel     = (addr_dat == PR_A);

  // Address decode for the per-channel low/high increment bytes
  always_comb begin
    sel_lo  = '0;
    sel_hi  = '0;
    sel_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_lo[i] = (addr_dat == BUS_ADDR_DATA_LEN'(CLKFRQ_ADDR + 2 * i));
      sel_hi[i] = (addr_dat == BUS_ADDR_DATA_LEN'(CLKFRQ_ADDR + 2 * i + 1));
      if (sel_lo[i]) begin
        sel_inc = inc[i];
      end else begin
        sel_inc = sel_inc;
      end
    end
    frq_lo = |sel_lo;
    frq_hi = |sel_hi;
  end

  // Period terminal count; on an apply cycle the next period already uses pending
  always_comb begin
    eff_ps   = sys_ce ? pending : clkps;
    cnt_mask = ~(8'hFF << eff_ps);
    term     = (cnt == cnt_mask);
    new_ps   = (bus_dat_in[3:0] > 4'd8) ? 4'd8 : bus_dat_in[3:0];
  end

`ifdef ATMEGA_CLK_PRESCALER_CH_GATE_EN
  assign adv = sys_ce;
`else
  assign adv = 1'b1;
`endif

  // Combinational read mux, forced to zero in reset or when not reading
  always_comb begin
    rd_val = 8'h00;
    if (rst || !rd_dat) begin
      rd_val = 8'h00;
    end else if (pr_sel) begin
      rd_val = {win_active, 3'b000, clkps};
    end else if (frq_hi) begin
      rd_val = temp;
    end else if (frq_lo) begin
      rd_val = sel_inc[7:0];
    end else begin
      rd_val = 8'h00;
    end
  end

  assign bus_dat_out = rd_val;

  // CLKPR change window and glitch-free system prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      clkps   <= PS_RST;
      pending <= PS_RST;
      win_cnt <= 3'd0;
      cnt     <= 8'd0;
      sys_ce  <= (PS_RST == 4'd0);
    end else begin
      if (sys_ce) begin
        clkps <= pending;
      end else begin
        clkps <= clkps;
      end
      if (term) begin
        cnt    <= 8'd0;
        sys_ce <= 1'b1;
      end else begin
        cnt    <= cnt + 8'd1;
        sys_ce <= 1'b0;
      end
      if (wr_dat && pr_sel && bus_dat_in == 8'h80) begin
        win_cnt <= 3'd4;
      end else if (wr_dat && pr_sel && !bus_dat_in[7] && win_active) begin
        pending <= new_ps;
        win_cnt <= 3'd0;
      end else if (win_active) begin
        win_cnt <= win_cnt - 3'd1;
      end else begin
        win_cnt <= 3'd0;
      end
    end
  end

  // Increment registers behind the shared 16-bit TEMP byte
  always_ff @(posedge clk) begin
    if (rst) begin
      temp <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) inc[i] <= '0;
    end else if (wr_dat && frq_hi) begin
      temp <= bus_dat_in;
    end else if (wr_dat && frq_lo) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_lo[i]) inc[i] <= {temp, bus_dat_in};
      end
    end else if (rd_dat && frq_lo) begin
      temp <= sel_inc[15:8];
    end else begin
      temp <= temp;
    end
  end

  // 17-bit phase sums; bit ACC_W is the overflow carry
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // DDS accumulators with registered carry pulse and toggle output
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_ce  <= '0;
      ch_tog <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (adv) begin
          acc[i]    <= sum[i][ACC_W-1:0];
          ch_ce[i]  <= sum[i][ACC_W];
          ch_tog[i] <= ch_tog[i] ^ sum[i][ACC_W];
        end else begin
          ch_ce[i]  <= 1'b0;
        end
      end
    end
  end

endmodule
